// File: rtl/regfile_2r1w_sb.sv
// Two-read / one-write register file with a pending-write scoreboard.
// Reads are registered (latency 1) with write-first forwarding; reads of a
// reserved register are refused and flagged as hazards. Optional hardwired
// zero register at address 0.
module regfile_2r1w_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  // Read port A
  input  logic                         rd_en_a,
  input  logic [AW-1:0]                rs_a,
  output logic [XLEN-1:0]              rd_data_a,
  output logic                         rd_valid_a,
  output logic                         hazard_a,
  // Read port B
  input  logic                         rd_en_b,
  input  logic [AW-1:0]                rs_b,
  output logic [XLEN-1:0]              rd_data_b,
  output logic                         rd_valid_b,
  output logic                         hazard_b,
  // Writeback
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [XLEN-1:0]              wr_data,
  // Reservation
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  output logic                         rsv_err,
  output logic [$clog2(NREGS+1)-1:0]   pend_count
);

  localparam int unsigned CW     = $clog2(NREGS + 1);
  localparam logic        ZeroEn = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [XLEN-1:0]  rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic             rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
  logic             rsv_err_q, rsv_err_d;
  logic [CW-1:0]    pend_count_q, pend_count_d;

  logic             wr_ok, rsv_ok;
  logic [XLEN-1:0]  rd_val_a, rd_val_b;

  // Writes and reservations to the hardwired zero register have no effect.
  assign wr_ok  = wr_en & ~(ZeroEn & (wr_addr == '0));
  assign rsv_ok = rsv_en & ~(ZeroEn & (rsv_addr == '0));

  // A same-cycle writeback to the source resolves the hazard.
  assign hazard_a = rd_en_a & pend_q[rs_a] & ~(wr_en & (wr_addr == rs_a));
  assign hazard_b = rd_en_b & pend_q[rs_b] & ~(wr_en & (wr_addr == rs_b));

  // Register 0 is never written when hardwired, so it always holds 0.
  assign rd_val_a = (wr_ok && (wr_addr == rs_a)) ? wr_data : regs_q[rs_a];
  assign rd_val_b = (wr_ok && (wr_addr == rs_b)) ? wr_data : regs_q[rs_b];

  // Read port next state: accepted reads load data, refused/idle ones hold it.
  always_comb begin
    rd_data_a_d  = rd_data_a_q;
    rd_valid_a_d = 1'b0;
    rd_data_b_d  = rd_data_b_q;
    rd_valid_b_d = 1'b0;
    if (rd_en_a && !hazard_a) begin
      rd_data_a_d  = rd_val_a;
      rd_valid_a_d = 1'b1;
    end
    if (rd_en_b && !hazard_b) begin
      rd_data_b_d  = rd_val_b;
      rd_valid_b_d = 1'b1;
    end
  end

  // Scoreboard next state: a same-cycle reservation overrides the clearing write.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[wr_addr]  = 1'b0;
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    if (ZeroEn) pend_d[0] = 1'b0;
    rsv_err_d = rsv_ok & pend_q[rsv_addr] & ~(wr_en & (wr_addr == rsv_addr));
    pend_count_d = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      pend_count_d = pend_count_d + CW'(pend_d[i]);
    end
  end

  // Register file storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read outputs, scoreboard and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_a_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_data_b_q  <= '0;
      rd_valid_b_q <= 1'b0;
      pend_q       <= '0;
      rsv_err_q    <= 1'b0;
      pend_count_q <= '0;
    end else begin
      rd_data_a_q  <= rd_data_a_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_b_q <= rd_valid_b_d;
      pend_q       <= pend_d;
      rsv_err_q    <= rsv_err_d;
      pend_count_q <= pend_count_d;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_b = rd_valid_b_q;
  assign rsv_err    = rsv_err_q;
  assign pend_count = pend_count_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: directed vectors, a behavioural model compared
// every cycle, and literal expectations at key points of each scenario.
module tb_regfile_2r1w_sb;

  localparam int N = 32;

  logic        clk;
  logic        reset;
  logic        rd_en_a, rd_en_b, wr_en, rsv_en;
  logic [4:0]  rs_a, rs_b, wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, hazard_a, hazard_b, rsv_err;
  logic [5:0]  pend_count;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  regfile_2r1w_sb dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en_a    (rd_en_a),
    .rs_a       (rs_a),
    .rd_data_a  (rd_data_a),
    .rd_valid_a (rd_valid_a),
    .hazard_a   (hazard_a),
    .rd_en_b    (rd_en_b),
    .rs_b       (rs_b),
    .rd_data_b  (rd_data_b),
    .rd_valid_b (rd_valid_b),
    .hazard_b   (hazard_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rsv_err    (rsv_err),
    .pend_count (pend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg [N];
  bit          m_pend [N];
  logic [31:0] m_rd_a = 0, m_rd_b = 0;
  bit          m_val_a = 0, m_val_b = 0, m_err = 0;
  int          m_cnt = 0;

  function automatic bit m_hz(input logic en, input logic [4:0] rs);
    return en && m_pend[rs] && !(wr_en && wr_addr == rs);
  endfunction

  function automatic logic [31:0] m_val(input logic [4:0] rs);
    if (wr_en && wr_addr == rs && rs != 0) return wr_data;
    if (rs == 0) return 32'h0;
    return m_reg[rs];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_reg[i]  = 0;
        m_pend[i] = 0;
      end
      m_rd_a = 0; m_rd_b = 0; m_val_a = 0; m_val_b = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_val_a = rd_en_a && !m_hz(rd_en_a, rs_a);
      if (m_val_a) m_rd_a = m_val(rs_a);
      m_val_b = rd_en_b && !m_hz(rd_en_b, rs_b);
      if (m_val_b) m_rd_b = m_val(rs_b);
      m_err = rsv_en && rsv_addr != 0 && m_pend[rsv_addr] && !(wr_en && wr_addr == rsv_addr);
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  = wr_data;
        m_pend[wr_addr] = 0;
      end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1;
      m_cnt = 0;
      for (int i = 0; i < N; i++) m_cnt += int'(m_pend[i]);
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      chk("cyc_hazard_a", 32'(hazard_a), 32'(m_hz(rd_en_a, rs_a)));
      chk("cyc_hazard_b", 32'(hazard_b), 32'(m_hz(rd_en_b, rs_b)));
      chk("cyc_valid_a", 32'(rd_valid_a), 32'(m_val_a));
      chk("cyc_valid_b", 32'(rd_valid_b), 32'(m_val_b));
      chk("cyc_data_a", rd_data_a, m_rd_a);
      chk("cyc_data_b", rd_data_b, m_rd_b);
      chk("cyc_rsv_err", 32'(rsv_err), 32'(m_err));
      chk("cyc_pend_count", 32'(pend_count), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rd_en_a = 0; rs_a = 0; rd_en_b = 0; rs_b = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #3 reset = 1'b0;
    run = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pend_count", 32'(pend_count), 0);
    chk("rst_valid_a", 32'(rd_valid_a), 0);
    chk("rst_data_b", rd_data_b, 0);
    reset = 1'b1;

    // Read every address on both ports after reset.
    for (int i = 0; i < N; i++) begin
      idle();
      rd_en_a = 1; rs_a = 5'(i);
      rd_en_b = 1; rs_b = 5'(31 - i);
      tick();
      chk("rdall_data_a", rd_data_a, 0);
      chk("rdall_valid_b", 32'(rd_valid_b), 1);
    end

    // Write-first forwarding, then a plain read of the stored value.
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_en_a = 1; rs_a = 5;
    tick();
    chk("fwd_data_a", rd_data_a, 32'hDEADBEEF);
    idle(); rd_en_a = 1; rs_a = 5; rd_en_b = 1; rs_b = 5;
    tick();
    chk("reread_data_a", rd_data_a, 32'hDEADBEEF);
    chk("reread_data_b", rd_data_b, 32'hDEADBEEF);

    // Hardwired zero register ignores writes and reservations.
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rsv_en = 1; rsv_addr = 0;
    tick();
    chk("zero_rsv_err", 32'(rsv_err), 0);
    chk("zero_pend_count", 32'(pend_count), 0);
    idle(); rd_en_a = 1; rs_a = 0;
    tick();
    chk("zero_read_a", rd_data_a, 0);
    chk("zero_valid_a", 32'(rd_valid_a), 1);

    // Hazard on a reserved source, cleared by a same-cycle writeback.
    idle(); rsv_en = 1; rsv_addr = 7;
    tick();
    chk("rsv7_pend_count", 32'(pend_count), 1);
    idle(); rd_en_b = 1; rs_b = 7;
    #1 chk("rsv7_hazard_b", 32'(hazard_b), 1);
    tick();
    chk("rsv7_valid_b", 32'(rd_valid_b), 0);
    chk("rsv7_hold_b", rd_data_b, 32'hDEADBEEF);
    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h77; rd_en_b = 1; rs_b = 7;
    #1 chk("wb7_hazard_b", 32'(hazard_b), 0);
    tick();
    chk("wb7_data_b", rd_data_b, 32'h77);
    chk("wb7_valid_b", 32'(rd_valid_b), 1);
    chk("wb7_pend_count", 32'(pend_count), 0);

    // Double reservation error, then reserve+write in the same cycle.
    idle(); rsv_en = 1; rsv_addr = 3;
    tick();
    chk("rsv3a_err", 32'(rsv_err), 0);
    idle(); rsv_en = 1; rsv_addr = 3;
    tick();
    chk("rsv3b_err", 32'(rsv_err), 1);
    chk("rsv3b_pend_count", 32'(pend_count), 1);
    idle();
    tick();
    chk("rsv3_err_pulse_end", 32'(rsv_err), 0);
    idle(); rsv_en = 1; rsv_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h333;
    tick();
    chk("rsvwr3_err", 32'(rsv_err), 0);
    chk("rsvwr3_pend_count", 32'(pend_count), 1);
    idle(); rd_en_a = 1; rs_a = 3;
    #1 chk("rsvwr3_hazard_a", 32'(hazard_a), 1);
    tick();
    chk("rsvwr3_valid_a", 32'(rd_valid_a), 0);
    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'h444; rd_en_a = 1; rs_a = 3;
    tick();
    chk("wb3_data_a", rd_data_a, 32'h444);
    chk("wb3_pend_count", 32'(pend_count), 0);

    // Reserve 1..31 and pull reset mid-sequence.
    for (int i = 1; i < N; i++) begin
      idle(); rsv_en = 1; rsv_addr = 5'(i); rd_en_a = 1; rs_a = 5;
      if (i == 20) begin
        chk("pre_rst_pend_count", 32'(pend_count), 19);
        chk("pre_rst_data_a", rd_data_a, 32'hDEADBEEF);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pend_count", 32'(pend_count), 0);
        chk("mid_rst_data_a", rd_data_a, 0);
        chk("mid_rst_data_b", rd_data_b, 0);
        chk("mid_rst_valid_a", 32'(rd_valid_a), 0);
        chk("mid_rst_rsv_err", 32'(rsv_err), 0);
      end
      tick();
    end
    reset = 1'b1;
    for (int i = 1; i < N; i++) begin
      idle(); rd_en_a = 1; rs_a = 5'(i); rd_en_b = 1; rs_b = 5'(i);
      #1 chk("post_rst_hazard_a", 32'(hazard_a), 0);
      tick();
      chk("post_rst_data_b", rd_data_b, 0);
      chk("post_rst_valid_a", 32'(rd_valid_a), 1);
    end
    idle();
    tick();
    tick();
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
